if_stage: RTL



---
 rtl/riscv_pkg.sv | 32 +++
 rtl/if_fifo.sv | 79 +++++++
 rtl/if_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: data width, NOP encoding, default reset PC,
// base opcodes and the fetch-buffer entry type.
package riscv_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Base opcodes decoded by the controller
   localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
   localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
   localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
   localparam logic [6:0] OPC_STORE  = 7'b010_0011;
   localparam logic [6:0] OPC_OP     = 7'b011_0011;
   localparam logic [6:0] OPC_LUI    = 7'b011_0111;
   localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
   localparam logic [6:0] OPC_JALR   = 7'b110_0111;
   localparam logic [6:0] OPC_JAL    = 7'b110_1111;
   localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

   // One buffered fetch: the instruction word and the PC it came from
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   // Word-align an address by clearing the low two bits
   function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fifo.sv
// Show-ahead FIFO of {instr, pc} entries. The head entry is visible on
// 'head' whenever the FIFO is non-empty; flush empties it in one cycle.
module if_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [CW-1:0] count,
   output logic         empty,
   output logic         full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   // Pointer increment that also wraps for non-power-of-two depths
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign count   = cnt_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Next-state for storage, pointers and occupancy; flush wins over push/pop
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues credit-limited requests over
// req/gnt/rvalid, buffers responses with their PCs and hands them to decode.
// A redirect restarts fetch at the target and discards every in-flight reply.
module if_stage
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   input  logic        id_ready
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;
   logic [31:0]   last_pc_q, last_pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] drop_q, drop_d;

   fetch_entry_t  fifo_head, push_data;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_empty, fifo_full, push;

   logic          pop, fire, rsp, credit;
   logic [CW:0]   in_use;

   // Handshakes: credit counts in-flight plus buffered fetches, minus this
   // cycle's pop. The rst_n term keeps the request low while reset is held.
   always_comb begin
      id_valid  = ~fifo_empty & ~redirect_valid;
      pop       = id_valid & id_ready;
      in_use    = {1'b0, out_q} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};
      credit    = (in_use < (CW+1)'(FIFO_DEPTH));
      imem_req  = rst_n & credit & ~redirect_valid;
      imem_addr = pc_q;
      fire      = imem_req & imem_gnt;
      // A response with nothing outstanding is stray and ignored
      rsp       = imem_rvalid & (out_q != '0);
      id_instr  = fifo_empty ? NOP_INSTR : fifo_head.instr;
      id_pc     = fifo_empty ? last_pc_q : fifo_head.pc;
   end

   // PC, response-PC, outstanding and drop bookkeeping; redirect has priority
   always_comb begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      drop_d    = drop_q;
      push      = 1'b0;
      push_data = '{instr: imem_rdata, pc: resp_pc_q};
      out_d     = out_q + CW'(fire) - CW'(rsp);
      last_pc_d = fifo_empty ? last_pc_q : fifo_head.pc;
      if (redirect_valid) begin
         pc_d      = pc_align(redirect_pc);
         resp_pc_d = pc_align(redirect_pc);
         // Anything still in flight after this cycle belongs to the old path
         drop_d    = out_q - CW'(rsp);
      end else begin
         if (fire) pc_d = pc_q + 32'd4;
         if (rsp) begin
            if (drop_q != '0) begin
               drop_d = drop_q - 1'b1;
            end else begin
               push      = 1'b1;
               resp_pc_d = resp_pc_q + 32'd4;
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         last_pc_q <= '0;
         out_q     <= '0;
         drop_q    <= '0;
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         last_pc_q <= last_pc_d;
         out_q     <= out_d;
         drop_q    <= drop_d;
      end
   end

   if_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (fifo_head),
      .count     (fifo_cnt),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   // Credit must keep outstanding bounded and never push into a full buffer
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (out_q <= CW'(FIFO_DEPTH));
         assert (!(push && fifo_full && !pop));
      end
   end

endmodule
